// File: rtl/seq_div_pkg.sv
// -----------------------------------------------------------------------------
// seq_div_pkg
// Shared types and helpers for the sequential signed divider.
//   - div_state_e : controller states (IDLE, RUN, FIX, DONE)
//   - DIV_WIDTH   : default operand width
//   - sat_pos/sat_neg : saturation patterns for a given width
//   - abs_u       : unsigned magnitude of a two's-complement value of a given
//                   width (supports widths up to 32, so WIDTH <= 16)
// -----------------------------------------------------------------------------
package seq_div_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

    // Largest positive value representable in 'width' signed bits.
    function automatic logic [31:0] sat_pos(input int width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    // Most negative value in 'width' signed bits (as an unsigned bit pattern).
    function automatic logic [31:0] sat_neg(input int width);
        return 32'd1 << (width - 1);
    endfunction

    // Magnitude of the low 'width' bits of value, taken as two's complement.
    // The result is unsigned, so the most negative input maps to 2^(width-1)
    // without wrapping.
    function automatic logic [31:0] abs_u(input logic [31:0] value, input int width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        if (value[width-1]) begin
            return (~value + 32'd1) & mask;
        end
        return value & mask;
    endfunction

endpackage

// File: rtl/div_substep.sv
// -----------------------------------------------------------------------------
// div_substep
// One combinational restoring-division iteration.
//   rem_i  [WIDTH:0]   partial remainder (always < divisor magnitude)
//   bit_i              next dividend bit, shifted in at the LSB
//   dvs_i  [WIDTH-1:0] divisor magnitude
//   rem_o  [WIDTH:0]   new partial remainder
//   qbit_o             quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_substep #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic             qbit_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    assign shifted = {rem_i, bit_i};
    // One extra bit above the shifted value catches the borrow.
    assign diff    = shifted - {2'b00, dvs_i};
    assign qbit_o  = ~diff[WIDTH+1];
    assign rem_o   = qbit_o ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/seq_signed_divider.sv
// -----------------------------------------------------------------------------
// seq_signed_divider
// Multi-cycle signed divider: 2*WIDTH-bit dividend / WIDTH-bit divisor.
// Restoring division on magnitudes, one quotient bit per clock, then sign fix.
//   clk, rst_n (async, active-low)
//   start_i, dividend_i [2W], divisor_i [W]   request and operands
//   ready_o                                    request can be accepted
//   done_o                                     one-cycle result pulse
//   quotient_o, remainder_o [W]                results, held until next done
//   dbz_o, ovf_o                               divide-by-zero / overflow flags
// Optional feature macro SEQ_DIV_PENDING_EN: one-entry pending request buffer
// so a request issued while busy launches right after the current result.
// -----------------------------------------------------------------------------
module seq_signed_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [2*WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic               ready_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   quotient_o,
    output logic [WIDTH-1:0]   remainder_o,
    output logic               dbz_o,
    output logic               ovf_o
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));
    localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg(WIDTH));

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [WIDTH-1:0] dvd_lo_q, dvd_lo_d;   // low dividend bits, consumed MSB first
    logic [WIDTH-1:0] dvs_q, dvs_d;         // divisor magnitude
    logic [WIDTH-1:0] quo_q, quo_d;         // quotient magnitude
    logic             sgn_quo_q, sgn_quo_d;
    logic             sgn_rem_q, sgn_rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    // Operation source selected by the request path below.
    logic             launch;
    logic [W2-1:0]    src_dvd;
    logic [WIDTH-1:0] src_dvs;
    logic [W2-1:0]    src_dvd_abs;
    logic [WIDTH-1:0] src_dvs_abs;
    logic             src_sgn_quo;

`ifdef SEQ_DIV_PENDING_EN
    logic             pend_full_q, pend_full_d;
    logic [W2-1:0]    pend_dvd_q, pend_dvd_d;
    logic [WIDTH-1:0] pend_dvs_q, pend_dvs_d;

    always_comb begin
        pend_full_d = pend_full_q;
        pend_dvd_d  = pend_dvd_q;
        pend_dvs_d  = pend_dvs_q;
        ready_o     = !pend_full_q;
        // A buffered request has priority over a new one (ready is low then).
        src_dvd     = pend_full_q ? pend_dvd_q : dividend_i;
        src_dvs     = pend_full_q ? pend_dvs_q : divisor_i;
        launch      = (state_q == S_IDLE) && (pend_full_q || start_i);
        if ((state_q == S_IDLE) && pend_full_q) begin
            pend_full_d = 1'b0;
        end else if ((state_q != S_IDLE) && start_i && !pend_full_q) begin
            pend_full_d = 1'b1;
            pend_dvd_d  = dividend_i;
            pend_dvs_d  = divisor_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full_q <= 1'b0;
            pend_dvd_q  <= '0;
            pend_dvs_q  <= '0;
        end else begin
            pend_full_q <= pend_full_d;
            pend_dvd_q  <= pend_dvd_d;
            pend_dvs_q  <= pend_dvs_d;
        end
    end
`else
    always_comb begin
        ready_o = (state_q == S_IDLE) || (state_q == S_DONE);
        src_dvd = dividend_i;
        src_dvs = divisor_i;
        launch  = start_i && ready_o;
    end
`endif

    assign src_dvd_abs = W2'(abs_u(32'(src_dvd), W2));
    assign src_dvs_abs = WIDTH'(abs_u(32'(src_dvs), WIDTH));
    assign src_sgn_quo = src_dvd[W2-1] ^ src_dvs[WIDTH-1];

    logic [WIDTH:0] step_rem;
    logic           step_bit;

    div_substep #(.WIDTH(WIDTH)) u_step (
        .rem_i  (prem_q),
        .bit_i  (dvd_lo_q[WIDTH-1]),
        .dvs_i  (dvs_q),
        .rem_o  (step_rem),
        .qbit_o (step_bit)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prem_d      = prem_q;
        dvd_lo_d    = dvd_lo_q;
        dvs_d       = dvs_q;
        quo_d       = quo_q;
        sgn_quo_d   = sgn_quo_q;
        sgn_rem_d   = sgn_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (launch) begin
                    sgn_quo_d = src_sgn_quo;
                    sgn_rem_d = src_dvd[W2-1];
                    dvs_d     = src_dvs_abs;
                    // Upper half seeds the remainder: it is below the divisor
                    // whenever the quotient fits in WIDTH bits.
                    prem_d    = {1'b0, src_dvd_abs[W2-1:WIDTH]};
                    dvd_lo_d  = src_dvd_abs[WIDTH-1:0];
                    quo_d     = '0;
                    cnt_d     = CW'(WIDTH - 1);
                    if (src_dvs == '0) begin
                        state_d     = S_DONE;
                        dbz_d       = 1'b1;
                        ovf_d       = 1'b0;
                        quotient_d  = '1;
                        remainder_d = src_dvd[WIDTH-1:0];
                    end else if (src_dvd_abs[W2-1:WIDTH] >= src_dvs_abs) begin
                        state_d     = S_DONE;
                        dbz_d       = 1'b0;
                        ovf_d       = 1'b1;
                        quotient_d  = src_sgn_quo ? SAT_NEG : SAT_POS;
                        remainder_d = '0;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                prem_d   = step_rem;
                dvd_lo_d = dvd_lo_q << 1;
                quo_d    = {quo_q[WIDTH-2:0], step_bit};
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                dbz_d   = 1'b0;
                // Magnitude fits WIDTH unsigned bits but may exceed the signed range.
                if ((!sgn_quo_q && (quo_q > SAT_POS)) || (sgn_quo_q && (quo_q > SAT_NEG))) begin
                    ovf_d       = 1'b1;
                    quotient_d  = sgn_quo_q ? SAT_NEG : SAT_POS;
                    remainder_d = '0;
                end else begin
                    ovf_d       = 1'b0;
                    quotient_d  = sgn_quo_q ? -quo_q : quo_q;
                    remainder_d = sgn_rem_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            prem_q      <= '0;
            dvd_lo_q    <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            sgn_quo_q   <= 1'b0;
            sgn_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prem_q      <= prem_d;
            dvd_lo_q    <= dvd_lo_d;
            dvs_q       <= dvs_d;
            quo_q       <= quo_d;
            sgn_quo_q   <= sgn_quo_d;
            sgn_rem_q   <= sgn_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign done_o      = (state_q == S_DONE);
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;
    assign dbz_o       = dbz_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_signed_divider
// Self-checking bench: an arithmetic reference model predicts each result and
// the cycle its done pulse appears; one monitor compares on every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_signed_divider;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_i = 1'b0;
    logic [2*W-1:0] dividend_i = '0;
    logic [W-1:0]   divisor_i = '0;
    logic           ready_o, done_o, dbz_o, ovf_o;
    logic [W-1:0]   quotient_o, remainder_o;

    seq_signed_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .ready_o     (ready_o),
        .done_o      (done_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .dbz_o       (dbz_o),
        .ovf_o       (ovf_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] dvd;
        logic [W-1:0]   dvs;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           dbz;
        logic           ovf;
        int             due;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    logic [W-1:0] hold_q = '0;
    logic [W-1:0] hold_r = '0;
    logic         hold_dbz = 1'b0;
    logic         hold_ovf = 1'b0;

    // Reference: plain signed integer division, truncating toward zero.
    function automatic exp_t model(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        exp_t e;
        int a, b, qi, ri;
        e.dvd = dvd; e.dvs = dvs; e.dbz = 1'b0; e.ovf = 1'b0; e.due = 0;
        a = int'($signed(dvd));
        b = int'($signed(dvs));
        if (b == 0) begin
            e.dbz = 1'b1; e.q = '1; e.r = dvd[W-1:0];
        end else begin
            qi = a / b;
            ri = a % b;
            if (qi > 127) begin
                e.ovf = 1'b1; e.q = 8'h7F; e.r = '0;
            end else if (qi < -128) begin
                e.ovf = 1'b1; e.q = 8'h80; e.r = '0;
            end else begin
                e.q = W'(qi); e.r = W'(ri);
            end
        end
        return e;
    endfunction

    // Cycles between the sampling edge and the negedge where done is seen.
    function automatic int done_offset(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        int a, b;
        a = int'($signed(dvd)); if (a < 0) a = -a;
        b = int'($signed(dvs)); if (b < 0) b = -b;
        if (b == 0 || (a / b) >= 256) return 0;
        return W + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: result on done, held values otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done_o) begin
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
                end else begin
                    mon_e = expq.pop_front();
                    chk("done_cycle", cyc, mon_e.due);
                    chk("quotient", quotient_o, mon_e.q);
                    chk("remainder", remainder_o, mon_e.r);
                    chk("dbz", dbz_o, mon_e.dbz);
                    chk("ovf", ovf_o, mon_e.ovf);
                    hold_q = mon_e.q; hold_r = mon_e.r;
                    hold_dbz = mon_e.dbz; hold_ovf = mon_e.ovf;
                    $display("op %0d / %0d -> q=%0d r=%0d dbz=%0b ovf=%0b at cycle %0d",
                             $signed(mon_e.dvd), $signed(mon_e.dvs), $signed(quotient_o),
                             $signed(remainder_o), dbz_o, ovf_o, cyc);
                end
            end else begin
                chk("hold_quotient", quotient_o, hold_q);
                chk("hold_remainder", remainder_o, hold_r);
                chk("hold_dbz", dbz_o, hold_dbz);
                chk("hold_ovf", ovf_o, hold_ovf);
            end
        end
    end

    task automatic launch(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        exp_t e;
        int n;
        @(negedge clk);
        n = 0;
        while (!ready_o && n < 100) begin @(negedge clk); n++; end
        if (!ready_o) chk("ready_timeout", ready_o, 1);
        start_i = 1'b1; dividend_i = dvd; divisor_i = dvs;
        @(posedge clk);
        #1;
        e = model(dvd, dvs);
        e.due = cyc + done_offset(dvd, dvs);
        expq.push_back(e);
        start_i = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 200) begin @(posedge clk); n++; end
        if (expq.size() != 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: got %0d results pending, expected 0", expq.size());
            expq.delete();
        end
    endtask

    // Pins the model to a hand-computed result, then runs the operation.
    task automatic run_pinned(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                              input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic dbz, input logic ovf, input int lat);
        exp_t e;
        e = model(dvd, dvs);
        chk("pin_q", e.q, q);
        chk("pin_r", e.r, r);
        chk("pin_dbz", e.dbz, dbz);
        chk("pin_ovf", e.ovf, ovf);
        chk("pin_latency", done_offset(dvd, dvs), lat);
        launch(dvd, dvs);
        wait_done();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic signed [2*W-1:0] rnd;
        logic [W-1:0] rdvs;
        int first_due;

        // Reset state
        #1;
        chk("reset_ready", ready_o, 1);
        chk("reset_done", done_o, 0);
        chk("reset_quotient", quotient_o, 0);
        chk("reset_remainder", remainder_o, 0);
        chk("reset_flags", {dbz_o, ovf_o}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases with hand-computed results (latency: W+1 normal, 0 fast)
        run_pinned(-16'sd100,  8'sd7,  8'hF2, 8'hFE, 0, 0, W + 1);
        run_pinned(16'sd1000, -8'sd8,  8'h83, 8'h00, 0, 0, W + 1);
        run_pinned(-16'sd1024, 8'sd8,  8'h80, 8'h00, 0, 0, W + 1);
        run_pinned(16'sd1024,  8'sd8,  8'h7F, 8'h00, 0, 1, W + 1);
        run_pinned(16'h8000,  -8'sd1,  8'h7F, 8'h00, 0, 1, 0);
        run_pinned(16'h1234,   8'h00,  8'hFF, 8'h34, 1, 0, 0);
        run_pinned(16'sd77,   -8'sd3,  8'hE7, 8'h02, 0, 0, W + 1);
        run_pinned(16'sd16384, -8'sd128, 8'h80, 8'h00, 0, 0, W + 1);
        run_pinned(-16'sd16384, -8'sd128, 8'h7F, 8'h00, 0, 1, W + 1);
        run_pinned(16'sd5,     8'sd9,  8'h00, 8'h05, 0, 0, W + 1);

        // Start while busy
        launch(-16'sd100, 8'sd7);
        first_due = expq[0].due;
        repeat (3) @(negedge clk);
`ifdef SEQ_DIV_PENDING_EN
        chk("busy_ready", ready_o, 1);
`else
        chk("busy_ready", ready_o, 0);
`endif
        start_i = 1'b1; dividend_i = 16'sd200; divisor_i = 8'sd5;
        @(posedge clk);
        #1;
        start_i = 1'b0;
`ifdef SEQ_DIV_PENDING_EN
        begin
            exp_t e2;
            e2 = model(16'sd200, 8'sd5);
            e2.due = first_due + W + 3;
            expq.push_back(e2);
        end
`endif
        wait_done();
        repeat (W + 4) @(posedge clk);

        // Reset mid-RUN: aborts with no done pulse and clears outputs
        launch(16'sd1000, 8'sd3);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expq.delete();
        hold_q = '0; hold_r = '0; hold_dbz = 1'b0; hold_ovf = 1'b0;
        chk("midrun_reset_quotient", quotient_o, 0);
        chk("midrun_reset_remainder", remainder_o, 0);
        chk("midrun_reset_done", done_o, 0);
        chk("midrun_reset_ready", ready_o, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 3) @(posedge clk);
        run_pinned(16'sd77, -8'sd3, 8'hE7, 8'h02, 0, 0, W + 1);

        // Randomized operations
        for (int i = 0; i < 200; i++) begin
            rnd  = 2*W'($urandom);
            rnd  = rnd >>> $urandom_range(0, 15);
            rdvs = W'($urandom);
            case ($urandom_range(0, 9))
                0: rdvs = '0;
                1: rdvs = 8'h80;
                2: rnd  = 16'sh8000;
                default: ;
            endcase
            launch(rnd, rdvs);
            wait_done();
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
